// File: rtl/nios_button_pkg.sv
`default_nettype none
// ============================================================================
// nios_button_pkg : register map, EVENT word layout, event entry type  (rev 1.0)
// ============================================================================
package nios_button_pkg;

  localparam int NUM_BUTTONS = 4;
  localparam int BTN_ID_W    = 2;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP = 2'd2;
  localparam logic [1:0] ADDR_EVENT   = 2'd3;

  localparam int EV_VALID_BIT = 31;
  localparam int EV_OVF_BIT   = 30;
  localparam int EV_PRESS_BIT = 4;
  localparam int EV_ID_LSB    = 0;

  typedef struct packed {
    logic                press;
    logic [BTN_ID_W-1:0] id;
  } btn_event_t;

  localparam int EVENT_W = $bits(btn_event_t);

  // Entry fields are only reported when the FIFO head is valid.
  function automatic logic [31:0] event_word(input logic valid, input logic ovf,
                                             input btn_event_t ev);
    logic [31:0] w;
    w               = '0;
    w[EV_VALID_BIT] = valid;
    w[EV_OVF_BIT]   = ovf;
    if (valid) begin
      w[EV_PRESS_BIT]                      = ev.press;
      w[EV_ID_LSB +: BTN_ID_W]             = ev.id;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nios_button_debounce.sv
`default_nettype none
// ============================================================================
// nios_button_debounce : 2-flop sync, stable-level debounce, rise/fall pulses (rev 1.0)
// ============================================================================
module nios_button_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int          CNT_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic        RELEASED_PIN = ACTIVE_LOW;

  logic             sync0_q, sync1_q;
  logic             level_q, rise_q, fall_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sample;

  assign sample = sync1_q ^ ACTIVE_LOW;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync0_q <= RELEASED_PIN;
      sync1_q <= RELEASED_PIN;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync0_q <= pin_i;
      sync1_q <= sync0_q;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      if (sample == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        level_q <= sample;
        rise_q  <= sample;
        fall_q  <= ~sample;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule
`default_nettype wire

// File: rtl/nios_button_ctrl.sv
`default_nettype none
// ============================================================================
// nios_button_ctrl : Avalon-MM push-button controller with irq and event FIFO (rev 1.0)
// ============================================================================
module nios_button_ctrl import nios_button_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write_n,
  input  logic [31:0] writedata,
  input  logic [3:0]  in_port,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PTR_W = AW + 1;

  logic [NUM_BUTTONS-1:0] level, rise, fall;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
      nios_button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW)
      ) u_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .pin_i   (in_port[gi]),
        .level_o (level[gi]),
        .rise_o  (rise[gi]),
        .fall_o  (fall[gi])
      );
    end
  endgenerate

  logic [NUM_BUTTONS-1:0] edgecap_q, edgecap_d, mask_q;
  logic [NUM_BUTTONS-1:0] pend_press_q, pend_press_d, pend_release_q, pend_release_d;
  logic [NUM_BUTTONS-1:0] grant_press, grant_release;
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic                   overflow_q, overflow_d;
  logic [31:0]            readdata_q;
  logic                   irq_q;
  btn_event_t             mem_q [FIFO_DEPTH];
  btn_event_t             push_ev;
  logic                   push_req, push_ok, pop;
  logic                   fifo_empty, fifo_full, rd_en, wr_en;

  assign rd_en      = chipselect & read;
  assign wr_en      = chipselect & ~write_n;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = rd_en && (address == ADDR_EVENT) && !fifo_empty;
  assign push_ok    = push_req && (!fifo_full || pop);

  // Priority walk: lowest id first, press ahead of release for the same id.
  always_comb begin
    grant_press   = '0;
    grant_release = '0;
    push_req      = 1'b0;
    push_ev       = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (!push_req) begin
        if (pend_press_q[i]) begin
          grant_press[i] = 1'b1;
          push_req       = 1'b1;
          push_ev.press  = 1'b1;
          push_ev.id     = BTN_ID_W'(i);
        end else if (pend_release_q[i]) begin
          grant_release[i] = 1'b1;
          push_req         = 1'b1;
          push_ev.press    = 1'b0;
          push_ev.id       = BTN_ID_W'(i);
        end
      end
    end
  end

  // A granted flag is retired even when the push is dropped on a full FIFO.
  always_comb begin
    pend_press_d   = (pend_press_q & ~grant_press) | rise;
    pend_release_d = (pend_release_q & ~grant_release) | fall;
    edgecap_d      = edgecap_q;
    if (wr_en && (address == ADDR_EDGECAP))
      edgecap_d = edgecap_d & ~writedata[NUM_BUTTONS-1:0];
    edgecap_d  = edgecap_d | rise;
    overflow_d = overflow_q;
    if (wr_en && (address == ADDR_EVENT))
      overflow_d = 1'b0;
    if (push_req && fifo_full && !pop)
      overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecap_q      <= '0;
      mask_q         <= '0;
      pend_press_q   <= '0;
      pend_release_q <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      overflow_q     <= 1'b0;
      readdata_q     <= '0;
      irq_q          <= 1'b0;
    end else begin
      edgecap_q      <= edgecap_d;
      pend_press_q   <= pend_press_d;
      pend_release_q <= pend_release_d;
      overflow_q     <= overflow_d;
      irq_q          <= |(edgecap_q & mask_q);
      if (wr_en && (address == ADDR_IRQMASK))
        mask_q <= writedata[NUM_BUTTONS-1:0];
      if (push_ok)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      if (rd_en) begin
        case (address)
          ADDR_DATA:    readdata_q <= {{(32-NUM_BUTTONS){1'b0}}, level};
          ADDR_IRQMASK: readdata_q <= {{(32-NUM_BUTTONS){1'b0}}, mask_q};
          ADDR_EDGECAP: readdata_q <= {{(32-NUM_BUTTONS){1'b0}}, edgecap_q};
          default:      readdata_q <= event_word(!fifo_empty, overflow_q,
                                                 mem_q[rd_ptr_q[AW-1:0]]);
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem_q[wr_ptr_q[AW-1:0]] <= push_ev;
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_nios_button_ctrl.sv
`default_nettype none
// ============================================================================
// tb_nios_button_ctrl : directed scoreboard bench for nios_button_ctrl (rev 1.0)
// ============================================================================
module tb_nios_button_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        read = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [3:0]  in_port = 4'hF;
  logic [31:0] readdata;
  logic        irq;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q [$];
  string       tag_q [$];

  always #5 clk = ~clk;

  nios_button_ctrl #(
    .DEBOUNCE_CYCLES (16),
    .ACTIVE_LOW      (1'b1),
    .FIFO_DEPTH      (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .read       (read),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Read issued on a negedge; registered result compared one cycle later.
  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] e;
    string       t;
    address    = a;
    chipselect = 1'b1;
    read       = 1'b1;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    chipselect = 1'b0;
    read       = 1'b0;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, readdata, e);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic btn(input int i, input logic pressed);
    in_port[i] = ~pressed;
  endtask

  initial begin
    // 1: reset with all buttons released
    cycles(3);
    reset_n = 1'b1;
    cycles(2);
    check("reset_irq", {31'b0, irq}, 32'h0);
    rd(2'd0, 32'h0, "reset_data");
    rd(2'd3, 32'h0, "reset_event");

    // 2: bounce on btn0 is rejected, then a steady press is accepted once
    btn(0, 1'b1); cycles(10);
    btn(0, 1'b0); cycles(3);
    rd(2'd0, 32'h0, "bounce_data");
    btn(0, 1'b1); cycles(12);
    rd(2'd0, 32'h0, "early_data");
    cycles(8);
    rd(2'd0, 32'h1, "debounced_data");
    cycles(1);
    check("readdata_hold", readdata, 32'h1);
    rd(2'd3, 32'h8000_0010, "bounce_event");
    rd(2'd3, 32'h0, "bounce_single");

    // 3: edge capture, mask and irq
    btn(0, 1'b0); cycles(25);
    rd(2'd3, 32'h8000_0000, "release0_event");
    wr(2'd2, 32'hF);
    wr(2'd1, 32'h1);
    rd(2'd1, 32'h1, "irqmask_rb");
    check("irq_no_edge", {31'b0, irq}, 32'h0);
    btn(0, 1'b1); cycles(25);
    rd(2'd2, 32'h1, "edgecap_btn0");
    check("irq_set", {31'b0, irq}, 32'h1);
    wr(2'd2, 32'h1);
    check("irq_lag", {31'b0, irq}, 32'h1);
    cycles(1);
    check("irq_cleared", {31'b0, irq}, 32'h0);
    btn(0, 1'b0);
    btn(1, 1'b1); cycles(25);
    rd(2'd2, 32'h2, "edgecap_btn1");
    check("irq_masked", {31'b0, irq}, 32'h0);
    rd(2'd3, 32'h8000_0010, "t3_ev0");
    rd(2'd3, 32'h8000_0000, "t3_ev1");
    rd(2'd3, 32'h8000_0011, "t3_ev2");
    btn(1, 1'b0); cycles(25);
    rd(2'd3, 32'h8000_0001, "t3_ev3");
    wr(2'd2, 32'hF);

    // 4: simultaneous presses/releases arbitrate lowest id first
    btn(1, 1'b1); btn(3, 1'b1); cycles(25);
    btn(1, 1'b0); btn(3, 1'b0); cycles(25);
    rd(2'd3, 32'h8000_0011, "arb_ev0");
    rd(2'd3, 32'h8000_0013, "arb_ev1");
    rd(2'd3, 32'h8000_0001, "arb_ev2");
    rd(2'd3, 32'h8000_0003, "arb_ev3");
    rd(2'd3, 32'h0, "arb_empty");

    // 5: nine events into an 8-deep FIFO
    in_port = 4'h0; cycles(25);
    in_port = 4'hF; cycles(25);
    btn(0, 1'b1);   cycles(25);
    for (int i = 0; i < 4; i++)
      rd(2'd3, 32'hC000_0010 | i, $sformatf("ovf_press%0d", i));
    for (int i = 0; i < 4; i++)
      rd(2'd3, 32'hC000_0000 | i, $sformatf("ovf_release%0d", i));
    rd(2'd3, 32'h4000_0000, "ovf_empty");
    wr(2'd3, 32'h0);
    rd(2'd3, 32'h0, "ovf_cleared");

    // 6: asynchronous reset mid-debounce with entries queued
    wr(2'd1, 32'hF);
    btn(0, 1'b0); btn(1, 1'b1); btn(2, 1'b1); cycles(25);
    btn(3, 1'b1); cycles(12);
    rd(2'd0, 32'h6, "pre_reset_data");
    check("pre_reset_irq", {31'b0, irq}, 32'h1);
    #2 reset_n = 1'b0;
    #1 check("async_readdata", readdata, 32'h0);
    check("async_irq", {31'b0, irq}, 32'h0);
    cycles(2);
    reset_n = 1'b1;
    cycles(1);
    rd(2'd0, 32'h0, "post_reset_data");
    rd(2'd2, 32'h0, "post_reset_edgecap");
    rd(2'd3, 32'h0, "post_reset_event");
    check("post_reset_irq", {31'b0, irq}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
